// File: rtl/l2_mem_fill_ctrl_if.sv
// l2_mem_fill_ctrl_if: L2 miss/response and block memory port bundle.
// master = fill controller, slave = L2 plus memory side.
interface l2_mem_fill_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BLOCK_SIZE = 16
);
  logic                                  req_valid;
  logic                                  req_ready;
  logic [ADDR_WIDTH-1:0]                 req_addr;
  logic                                  req_wb;
  logic [ADDR_WIDTH-1:0]                 req_wb_addr;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] req_wb_data;
  logic                                  resp_valid;
  logic [ADDR_WIDTH-1:0]                 resp_addr;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] resp_data;
  logic                                  resp_err;
  logic                                  busy;
  logic [ADDR_WIDTH-1:0]                 mem_addr;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_out;
  logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] mem_data_in;
  logic                                  mem_read;
  logic                                  mem_write;
  logic                                  mem_hit;
  logic                                  mem_ready;

  modport master (
    input  req_valid, req_addr, req_wb, req_wb_addr, req_wb_data,
    input  mem_data_in, mem_hit, mem_ready,
    output req_ready, resp_valid, resp_addr, resp_data, resp_err,
    output busy, mem_addr, mem_data_out, mem_read, mem_write
  );

  modport slave (
    output req_valid, req_addr, req_wb, req_wb_addr, req_wb_data,
    output mem_data_in, mem_hit, mem_ready,
    input  req_ready, resp_valid, resp_addr, resp_data, resp_err,
    input  busy, mem_addr, mem_data_out, mem_read, mem_write
  );
endinterface

// File: rtl/l2_mem_fill_ctrl.sv
// l2_mem_fill_ctrl: one-at-a-time L2 miss fill with optional victim writeback.
// Define TIMEOUT_EN to bound memory wait states to TIMEOUT_CYCLES.
module l2_mem_fill_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int BLOCK_SIZE     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  l2_mem_fill_ctrl_if.master bus
);
  typedef logic [BLOCK_SIZE-1:0][DATA_WIDTH-1:0] blk_t;
  typedef enum logic [2:0] {
    IDLE, WB_ISSUE, WB_WAIT, RD_ISSUE, RD_WAIT, RESP
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] AMASK =
    ~ADDR_WIDTH'(BLOCK_SIZE - 1);

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] addr_q, wb_addr_q, resp_addr_q;
  blk_t                  wb_data_q, resp_data_q;
  logic                  hit_done;
  logic                  to_done;
  logic                  err_out;

  assign hit_done = (state == RD_WAIT) && bus.mem_ready && bus.mem_hit;

`ifdef TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          waiting;
  logic          err_q;

  assign waiting = (state == WB_WAIT) || (state == RD_WAIT);
  assign to_done = waiting && !bus.mem_ready &&
                   (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign err_out = err_q;

  // Cleared in the issue cycle so each wait phase starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == WB_ISSUE || state == RD_ISSUE)
        cnt <= '0;
      else if (waiting && cnt != CW'(TIMEOUT_CYCLES))
        cnt <= cnt + 1'b1;
      if (hit_done)
        err_q <= 1'b0;
      else if (to_done)
        err_q <= 1'b1;
    end
  end
`else
  assign to_done = 1'b0;
  assign err_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      resp_addr_q <= '0;
      resp_data_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.req_valid) begin
        addr_q    <= bus.req_addr & AMASK;
        wb_addr_q <= bus.req_wb_addr & AMASK;
        wb_data_q <= bus.req_wb_data;
      end
      if (hit_done) begin
        resp_addr_q <= addr_q;
        resp_data_q <= bus.mem_data_in;
      end else if (to_done) begin
        resp_addr_q <= addr_q;
        resp_data_q <= '0;
      end
    end
  end

  // Issue states ignore mem_ready: it may be left over from a prior beat.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:
        if (bus.req_valid)
          state_n = bus.req_wb ? WB_ISSUE : RD_ISSUE;
      WB_ISSUE: state_n = WB_WAIT;
      WB_WAIT:
        if (to_done)            state_n = RESP;
        else if (bus.mem_ready) state_n = RD_ISSUE;
      RD_ISSUE: state_n = RD_WAIT;
      RD_WAIT:
        if (to_done)            state_n = RESP;
        else if (bus.mem_ready)
          state_n = bus.mem_hit ? RESP : RD_ISSUE;
      RESP:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready    = (state == IDLE);
    bus.busy         = (state != IDLE);
    bus.mem_write    = (state == WB_ISSUE) || (state == WB_WAIT);
    bus.mem_read     = (state == RD_ISSUE) || (state == RD_WAIT);
    bus.mem_addr     = '0;
    bus.mem_data_out = '0;
    if (bus.mem_write) begin
      bus.mem_addr     = wb_addr_q;
      bus.mem_data_out = wb_data_q;
    end else if (bus.mem_read) begin
      bus.mem_addr = addr_q;
    end
    bus.resp_valid = (state == RESP);
    bus.resp_err   = (state == RESP) && err_out;
    bus.resp_addr  = resp_addr_q;
    bus.resp_data  = resp_data_q;
  end
endmodule

// File: tb/tb_l2_mem_fill_ctrl.sv
// tb_l2_mem_fill_ctrl: directed plus random fills against a block memory
// model; expected timing and data come from request-level arithmetic.
module tb_l2_mem_fill_ctrl;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BS = 16;
  localparam int TO = 8;
  typedef logic [BS-1:0][DW-1:0] blk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;

  // memory model controls
  bit   never_rdy = 1'b0;
  int   miss_left = 0;
  logic strobe_prev = 1'b0;
  logic m_rdy;

  l2_mem_fill_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW),
                        .BLOCK_SIZE(BS)) bus ();

  l2_mem_fill_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .BLOCK_SIZE(BS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic blk_t mem_blk(input logic [AW-1:0] a);
    blk_t b;
    for (int i = 0; i < BS; i++) b[i] = DW'(a + AW'(i));
    return b;
  endfunction

  // Memory: one ready pulse in the cycle after a strobe, then a gap.
  always @(negedge clk) begin
    m_rdy = !bus.mem_ready && strobe_prev && !never_rdy;
    strobe_prev = bus.mem_read | bus.mem_write;
    bus.mem_hit = 1'b0;
    bus.mem_data_in = '0;
    if (m_rdy && bus.mem_read) begin
      if (miss_left > 0) miss_left--;
      else begin
        bus.mem_hit = 1'b1;
        bus.mem_data_in = mem_blk(bus.mem_addr);
      end
    end
    bus.mem_ready = m_rdy;
  end

  task automatic chk(input string tag, input logic [BS*DW-1:0] obs,
                     input logic [BS*DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_req(input string tag, input logic [AW-1:0] a,
                         input bit wb, input logic [AW-1:0] wa,
                         input blk_t vd, input int misses);
    logic [AW-1:0] fa, va;
    int lat, resp_c, pulses, wr_n, rd_n, wr_bad, rd_bad, both, ord;
    fa = a & ~AW'(BS - 1);
    va = wa & ~AW'(BS - 1);
    lat = 3 + (wb ? 2 : 0) + 2 * misses;
    resp_c = -1; pulses = 0; wr_n = 0; rd_n = 0;
    wr_bad = 0; rd_bad = 0; both = 0; ord = 0;
    bus.req_addr = a;
    bus.req_wb = wb;
    bus.req_wb_addr = wa;
    bus.req_wb_data = vd;
    bus.req_valid = 1'b1;
    miss_left = misses;
    chk({tag, "_ready"}, bus.req_ready, 1);
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.mem_read && bus.mem_write) both++;
      if (bus.mem_write) begin
        wr_n++;
        if (rd_n > 0) ord++;
        if (bus.mem_addr !== va || bus.mem_data_out !== vd) wr_bad++;
      end
      if (bus.mem_read) begin
        rd_n++;
        if (bus.mem_addr !== fa) rd_bad++;
      end
      if (bus.resp_valid) begin
        pulses++;
        if (resp_c < 0) begin
          resp_c = c;
          chk({tag, "_raddr"}, bus.resp_addr, fa);
          chk({tag, "_rdata"}, bus.resp_data, mem_blk(fa));
          chk({tag, "_rerr"}, bus.resp_err, 0);
        end
      end
    end
    chk({tag, "_lat"}, resp_c, lat);
    chk({tag, "_pulses"}, pulses, 1);
    chk({tag, "_wr_n"}, wr_n, wb ? 2 : 0);
    chk({tag, "_rd_n"}, rd_n, 2 * (misses + 1));
    chk({tag, "_wr_bad"}, wr_bad, 0);
    chk({tag, "_rd_bad"}, rd_bad, 0);
    chk({tag, "_both"}, both, 0);
    chk({tag, "_order"}, ord, 0);
    chk({tag, "_idle"}, {bus.busy, bus.req_ready}, 2'b01);
    chk({tag, "_hold"}, bus.resp_data, mem_blk(fa));
  endtask

  initial begin
    blk_t vd;
    int   resp_c, rv, second_rd;
    int   rc_q[$];
    logic [AW-1:0] ra_q[$];
    blk_t rd_q[$];

    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    bus.req_wb = 1'b0;
    bus.req_wb_addr = '0;
    bus.req_wb_data = '0;
    bus.mem_ready = 1'b0;
    bus.mem_hit = 1'b0;
    bus.mem_data_in = '0;

    // reset state, request ignored while in reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_strobes", {bus.mem_read, bus.mem_write, bus.resp_valid}, 0);
    chk("rst_maddr", bus.mem_addr, 0);
    chk("rst_mdata", bus.mem_data_out, 0);
    chk("rst_resp", {bus.resp_err, bus.resp_addr}, 0);
    chk("rst_rdata", bus.resp_data, 0);
    bus.req_valid = 1'b1;
    @(negedge clk);
    chk("rst_ignore_req", bus.busy, 0);
    bus.req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    run_req("rd47", 32'h47, 1'b0, '0, '0, 0);

    for (int i = 0; i < BS; i++) vd[i] = DW'(32'hA0 + i);
    run_req("wb123", 32'h10, 1'b1, 32'h123, vd, 0);

    run_req("retry200", 32'h200, 1'b0, '0, '0, 2);

    // reset while waiting on a read
    bus.req_addr = 32'h80;
    bus.req_wb = 1'b0;
    bus.req_valid = 1'b1;
    miss_left = 0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("mid_rd_wait", bus.mem_read, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_ready", bus.req_ready, 1);
    chk("mid_rst_read", bus.mem_read, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_resp", bus.resp_valid, 0);
    rv = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.resp_valid) rv++;
    end
    chk("mid_no_resp", rv, 0);
    run_req("after_rst30", 32'h30, 1'b0, '0, '0, 0);

    // memory that never answers
    never_rdy = 1'b1;
    bus.req_addr = 32'h95;
    bus.req_wb = 1'b0;
    bus.req_valid = 1'b1;
    resp_c = -1;
`ifdef TIMEOUT_EN
    for (int c = 1; c <= 2 + TO + 3; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.resp_valid && resp_c < 0) begin
        resp_c = c;
        chk("to_err", bus.resp_err, 1);
        chk("to_data", bus.resp_data, 0);
      end
    end
    chk("to_lat", resp_c, 2 + TO);
    chk("to_idle", bus.busy, 0);
`else
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.resp_valid && resp_c < 0) resp_c = c;
    end
    chk("hang_busy", bus.busy, 1);
    chk("hang_read", bus.mem_read, 1);
    chk("hang_no_resp", resp_c, -1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    never_rdy = 1'b0;
    repeat (2) @(negedge clk);

    // requester holds req_valid across two requests
    bus.req_addr = 32'h0;
    bus.req_wb = 1'b0;
    bus.req_valid = 1'b1;
    miss_left = 0;
    second_rd = -1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) bus.req_addr = 32'h50;
      if (bus.mem_read && bus.mem_addr == 32'h50 && second_rd < 0) begin
        second_rd = c;
        bus.req_valid = 1'b0;
      end
      if (c == 3) chk("b2b_ready_in_resp", bus.req_ready, 0);
      if (bus.resp_valid) begin
        rc_q.push_back(c);
        ra_q.push_back(bus.resp_addr);
        rd_q.push_back(bus.resp_data);
      end
    end
    bus.req_valid = 1'b0;
    chk("b2b_n", rc_q.size(), 2);
    if (rc_q.size() == 2) begin
      chk("b2b_c0", rc_q[0], 3);
      chk("b2b_a0", ra_q[0], 32'h0);
      chk("b2b_d0", rd_q[0], mem_blk(32'h0));
      chk("b2b_c1", rc_q[1], rc_q[0] + 1 + 3);
      chk("b2b_a1", ra_q[1], 32'h50);
      chk("b2b_d1", rd_q[1], mem_blk(32'h50));
    end
    chk("b2b_rd_start", second_rd, 5);
    chk("b2b_idle", bus.busy, 0);

    // random traffic
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < BS; i++) vd[i] = $urandom;
      run_req("rand", $urandom & 32'h00FF_FFFF, 1'($urandom_range(0, 1)),
              $urandom, vd, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/l2_mem_fill_ctrl.md
Name: l2_mem_fill_ctrl

Overview:
- Initiator side of the L2-to-memory block interface: takes one L2 miss at a time, optionally writes back a dirty victim block, then fetches the missing block and returns it to L2.
- Drives the block-wide memory port (addr, block data, read/write strobes) and consumes the memory's ready/hit response.
- Sits between the L2 miss path and main memory.

Parameters:
DATA_WIDTH, 32, bits per word
ADDR_WIDTH, 32, word-address width
BLOCK_SIZE, 16, words per block; power of two; BLOCK_BITS = log2(BLOCK_SIZE)
TIMEOUT_CYCLES, 64, wait-state cycle limit (used only with TIMEOUT_EN)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  1  L2 miss request
req_ready  out  1  high only in IDLE
req_addr  in  ADDR_WIDTH  miss address; low BLOCK_BITS ignored
req_wb  in  1  victim writeback needed
req_wb_addr  in  ADDR_WIDTH  victim address; low BLOCK_BITS ignored
req_wb_data  in  BLOCK_SIZE x DATA_WIDTH  victim block
resp_valid  out  1  one-cycle fill-complete pulse
resp_addr  out  ADDR_WIDTH  block-aligned fill address
resp_data  out  BLOCK_SIZE x DATA_WIDTH  fill block; word i = address resp_addr+i
resp_err  out  1  valid with resp_valid; timeout indication
busy  out  1  state != IDLE
mem_addr  out  ADDR_WIDTH  block-aligned memory address
mem_data_out  out  BLOCK_SIZE x DATA_WIDTH  write block
mem_data_in  in  BLOCK_SIZE x DATA_WIDTH  read block
mem_read  out  1  read strobe
mem_write  out  1  write strobe
mem_hit  in  1  read data valid
mem_ready  in  1  memory response

Behaviour:
- Reset: state = IDLE, and all outputs are 0 except req_ready = 1. Any in-flight operation is dropped and no resp_valid is produced. req_valid is ignored in the reset cycle.
- All outputs are registered or decoded from registered state. There are no combinational paths from inputs to outputs.
- IDLE: if req_valid is high, latch the aligned req_addr, req_wb, the aligned req_wb_addr and req_wb_data. Go to WB_ISSUE if req_wb is set, else RD_ISSUE.
- WB_ISSUE: mem_write=1, mem_addr = victim address, mem_data_out = victim block. mem_ready is ignored because it may be stale from an earlier response. Go to WB_WAIT.
- WB_WAIT: hold mem_write, mem_addr and mem_data_out. On mem_ready, go to RD_ISSUE. mem_hit is don't-care for writes.
- RD_ISSUE: mem_read=1, mem_addr = fill address. mem_ready is ignored. Go to RD_WAIT.
- RD_WAIT: hold mem_read.
  - mem_ready && mem_hit: capture mem_data_in into resp_data and go to RESP.
  - mem_ready && !mem_hit: retry via RD_ISSUE, with no limit on retries.
- RESP: resp_valid=1 for exactly one cycle with resp_err=0, then go to IDLE. mem_read and mem_write are 0.
- mem_read and mem_write are never high at the same time.
- Latency, no writeback, memory that responds one cycle after strobe:
  - acceptance edge E0: mem_read is high from E0;
  - RD_WAIT is entered at E1 and sees mem_ready;
  - resp_valid is high in the cycle after E2.
- With a writeback, add 2 cycles.
- req_valid while busy is ignored because req_ready=0. The requester holds its request.
- A back-to-back request is accepted at the earliest in the cycle after RESP.
- resp_addr and resp_data hold their values until the next RESP.

Optional Feature:
- Macro TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WB_WAIT or RD_WAIT and increments each wait cycle.
  - If no completion arrives after TIMEOUT_CYCLES wait cycles, go to RESP with resp_err=1 and resp_data=0.
  - A writeback timeout skips the read.
  - A counter sized ceil(log2(TIMEOUT_CYCLES+1)) bits must not wrap.
- Undefined: the block waits indefinitely, resp_err is tied to 0, and no counter logic exists.

Test Plan:
- Memory model holds mem[i]=i and responds one cycle after the strobe. Request req_addr=0x47, req_wb=0 -> mem_read is high with mem_addr=0x40; resp_valid pulses once with resp_addr=0x40 and resp_data words 0x40..0x4F, 2 cycles after acceptance.
- Request req_wb=1, req_wb_addr=0x123, victim words 0xA0..0xAF, req_addr=0x10 -> first mem_write with mem_addr=0x120 and that block; then mem_read at 0x10; resp_data is 0x10..0x1F; no cycle has both strobes high.
- Memory returns mem_ready=1, mem_hit=0 twice and then a hit, for req_addr=0x200 -> two RD_ISSUE retries; exactly one resp_valid with data 0x200..0x20F.
- Assert rst in RD_WAIT -> next cycle is IDLE with req_ready=1 and mem_read=0; no resp_valid; a new request at 0x30 completes normally.
- With TIMEOUT_EN and TIMEOUT_CYCLES=8, the memory never asserts ready -> resp_valid with resp_err=1 and resp_data=0 after 8 wait cycles, then IDLE. Without TIMEOUT_EN the block is still busy after 100 cycles.
- Hold req_valid continuously with addresses 0x0 then 0x50 -> the second request is accepted only in the cycle after the first RESP; responses come in order with correct data.
